// File: rtl/wb_commit_unit.sv
// Writeback/commit stage: registers the RF write and result, counts retired
// instructions, and sequences traps (capture, timed flush, wait for ack).
module wb_commit_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RF_AW        = 5,
  parameter int unsigned CAUSE_W      = 5,
  parameter int unsigned INSTRET_W    = 64,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 stall_i,
  input  logic [1:0]           data_sel_i,
  input  logic [XLEN-1:0]      pc_i,
  input  logic                 is_comp_i,
  input  logic [XLEN-1:0]      alu_result_i,
  input  logic [XLEN-1:0]      read_data_i,
  input  logic [XLEN-1:0]      csr_rdata_i,
  input  logic [RF_AW-1:0]     rd_addr_i,
  input  logic                 rf_rw_en_i,
  input  logic                 exc_valid_i,
  input  logic [CAUSE_W-1:0]   exc_cause_i,
  input  logic                 instret_inhibit_i,
  input  logic                 trap_ack_i,
  output logic                 rf_we_o,
  output logic [RF_AW-1:0]     rf_waddr_o,
  output logic [XLEN-1:0]      wb_data_o,
  output logic [XLEN-1:0]      wb_pc_o,
  output logic                 retire_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic                 flush_o,
  output logic                 trap_active_o,
  output logic [CAUSE_W-1:0]   trap_cause_o,
  output logic [XLEN-1:0]      trap_epc_o
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_d;
  logic             trap_active_d;

  logic             accept;
  logic             commit;
  logic             take_trap;
  logic [XLEN-1:0]  link_pc;
  logic [XLEN-1:0]  wb_mux;

  assign accept    = valid_i && !stall_i && (state_q == IDLE);
  assign commit    = accept && !exc_valid_i;
  assign take_trap = accept && exc_valid_i;
  assign link_pc   = pc_i + (is_comp_i ? XLEN'(2) : XLEN'(4));

  // Writeback source select
  always_comb begin
    wb_mux = alu_result_i;
    unique case (data_sel_i)
      2'b00:   wb_mux = alu_result_i;
      2'b01:   wb_mux = read_data_i;
      2'b10:   wb_mux = link_pc;
      2'b11:   wb_mux = csr_rdata_i;
      default: wb_mux = alu_result_i;
    endcase
  end

  // Trap sequencer next-state; flush/trap_active are next values of the registered outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flush_d       = 1'b0;
    trap_active_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take_trap) begin
          state_d       = FLUSH;
          cnt_d         = CNT_W'(FLUSH_CYCLES - 1);
          flush_d       = 1'b1;
          trap_active_d = 1'b1;
        end
      end
      FLUSH: begin
        trap_active_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = WAIT_ACK;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (trap_ack_i) begin
          state_d = IDLE;
        end else begin
          trap_active_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      flush_o       <= 1'b0;
      trap_active_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_o       <= flush_d;
      trap_active_o <= trap_active_d;
    end
  end

  // Commit datapath, trap capture and retired-instruction counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= '0;
      wb_data_o    <= '0;
      wb_pc_o      <= '0;
      retire_o     <= 1'b0;
      instret_o    <= '0;
      trap_cause_o <= '0;
      trap_epc_o   <= '0;
    end else begin
      rf_we_o  <= commit && rf_rw_en_i && (rd_addr_i != '0);
      retire_o <= commit;
      if (commit) begin
        rf_waddr_o <= rd_addr_i;
        wb_data_o  <= wb_mux;
        wb_pc_o    <= pc_i;
      end else if (take_trap) begin
        wb_pc_o      <= pc_i;
        trap_epc_o   <= pc_i;
        trap_cause_o <= exc_cause_i;
      end
      if (commit && !instret_inhibit_i) begin
        instret_o <= instret_o + INSTRET_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed scenarios plus random traffic, checked by a
// cycle-level reference model feeding a scoreboard queue drained by a monitor.
module tb_wb_commit_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CW   = 5;
  localparam int unsigned IW   = 4;
  localparam int unsigned FC   = 2;

  logic            clk_i, rst_ni;
  logic            valid_i, stall_i, is_comp_i, rf_rw_en_i, exc_valid_i;
  logic            instret_inhibit_i, trap_ack_i;
  logic [1:0]      data_sel_i;
  logic [XLEN-1:0] pc_i, alu_result_i, read_data_i, csr_rdata_i;
  logic [AW-1:0]   rd_addr_i;
  logic [CW-1:0]   exc_cause_i;
  logic            rf_we_o, retire_o, flush_o, trap_active_o;
  logic [AW-1:0]   rf_waddr_o;
  logic [XLEN-1:0] wb_data_o, wb_pc_o, trap_epc_o;
  logic [IW-1:0]   instret_o;
  logic [CW-1:0]   trap_cause_o;

  wb_commit_unit #(
    .XLEN(XLEN), .RF_AW(AW), .CAUSE_W(CW), .INSTRET_W(IW), .FLUSH_CYCLES(FC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .stall_i(stall_i),
    .data_sel_i(data_sel_i), .pc_i(pc_i), .is_comp_i(is_comp_i),
    .alu_result_i(alu_result_i), .read_data_i(read_data_i), .csr_rdata_i(csr_rdata_i),
    .rd_addr_i(rd_addr_i), .rf_rw_en_i(rf_rw_en_i), .exc_valid_i(exc_valid_i),
    .exc_cause_i(exc_cause_i), .instret_inhibit_i(instret_inhibit_i),
    .trap_ack_i(trap_ack_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .wb_data_o(wb_data_o), .wb_pc_o(wb_pc_o), .retire_o(retire_o),
    .instret_o(instret_o), .flush_o(flush_o), .trap_active_o(trap_active_o),
    .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic [IW-1:0]   instret;
  } commit_t;

  typedef struct {
    logic [XLEN-1:0] epc;
    logic [CW-1:0]   cause;
  } trap_t;

  commit_t exp_q[$];
  trap_t   trap_q[$];
  int      ntests = 0;
  int      nerrs  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_data(input logic [1:0] sel, input logic [XLEN-1:0] pc,
                                               input logic comp, input logic [XLEN-1:0] alu,
                                               input logic [XLEN-1:0] ld, input logic [XLEN-1:0] csr);
    logic [XLEN-1:0] step;
    step = comp ? 32'd2 : 32'd4;
    case (sel)
      2'd0:    return alu;
      2'd1:    return ld;
      2'd2:    return pc + step;
      default: return csr;
    endcase
  endfunction

  // Reference model: trap modelled as "busy" plus remaining flush cycles
  logic            m_busy;
  int              m_flush_left;
  logic [IW-1:0]   m_instret;
  logic [AW-1:0]   m_waddr;
  logic [XLEN-1:0] m_data, m_pc, m_epc;
  logic [CW-1:0]   m_cause;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy = 1'b0; m_flush_left = 0; m_instret = '0;
      m_waddr = '0; m_data = '0; m_pc = '0; m_epc = '0; m_cause = '0;
      exp_q.delete();
      trap_q.delete();
    end else if (m_busy) begin
      if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
      else if (trap_ack_i) m_busy = 1'b0;
    end else if (valid_i && !stall_i) begin
      if (exc_valid_i) begin
        m_busy = 1'b1; m_flush_left = FC;
        m_epc = pc_i; m_cause = exc_cause_i; m_pc = pc_i;
        trap_q.push_back('{epc: pc_i, cause: exc_cause_i});
      end else begin
        if (!instret_inhibit_i) m_instret = m_instret + 4'd1;
        m_waddr = rd_addr_i;
        m_data  = ref_data(data_sel_i, pc_i, is_comp_i, alu_result_i, read_data_i, csr_rdata_i);
        m_pc    = pc_i;
        exp_q.push_back('{we: rf_rw_en_i && (rd_addr_i != 0), waddr: m_waddr,
                          data: m_data, pc: pc_i, instret: m_instret});
      end
    end
  end

  // Monitor: drain scoreboard on each retire/trap, compare persistent state every cycle
  commit_t mon_c;
  trap_t   mon_t;
  logic    prev_ta;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_ta = 1'b0;
    end else begin
      if (retire_o) begin
        if (exp_q.size() == 0) check("retire_spurious", 1, 0);
        else begin
          mon_c = exp_q.pop_front();
          check("commit_we", rf_we_o, mon_c.we);
          check("commit_waddr", rf_waddr_o, mon_c.waddr);
          check("commit_data", wb_data_o, mon_c.data);
          check("commit_pc", wb_pc_o, mon_c.pc);
          check("commit_instret", instret_o, mon_c.instret);
        end
      end else begin
        check("we_without_retire", rf_we_o, 0);
      end
      if (trap_active_o && !prev_ta) begin
        if (trap_q.size() == 0) check("trap_spurious", 1, 0);
        else begin
          mon_t = trap_q.pop_front();
          check("trap_epc_capture", trap_epc_o, mon_t.epc);
          check("trap_cause_capture", trap_cause_o, mon_t.cause);
        end
      end
      prev_ta = trap_active_o;
      check("flush", flush_o, m_flush_left > 0);
      check("trap_active", trap_active_o, m_busy);
      check("instret", instret_o, m_instret);
      check("wb_pc", wb_pc_o, m_pc);
      check("wb_data_hold", wb_data_o, m_data);
      check("waddr_hold", rf_waddr_o, m_waddr);
      check("epc_hold", trap_epc_o, m_epc);
      check("cause_hold", trap_cause_o, m_cause);
    end
  end

  task automatic clear_in();
    valid_i = 0; stall_i = 0; is_comp_i = 0; rf_rw_en_i = 0; exc_valid_i = 0;
    instret_inhibit_i = 0; trap_ack_i = 0; data_sel_i = 0; pc_i = 0;
    alu_result_i = 0; read_data_i = 0; csr_rdata_i = 0; rd_addr_i = 0; exc_cause_i = 0;
  endtask

  // Present one instruction for one unstalled cycle, returning at the following negedge
  task automatic send(input logic [1:0] sel, input logic [31:0] pc, input logic comp,
                      input logic [31:0] alu, input logic [4:0] rd, input logic we,
                      input logic exc, input logic [4:0] cause);
    @(negedge clk_i);
    valid_i = 1; stall_i = 0; data_sel_i = sel; pc_i = pc; is_comp_i = comp;
    alu_result_i = alu; read_data_i = ~alu; csr_rdata_i = alu ^ 32'h5a5a_0000;
    rd_addr_i = rd; rf_rw_en_i = we; exc_valid_i = exc; exc_cause_i = cause;
    @(negedge clk_i);
    valid_i = 0; exc_valid_i = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rf_we"}, rf_we_o, 0);
    check({tag, "_waddr"}, rf_waddr_o, 0);
    check({tag, "_data"}, wb_data_o, 0);
    check({tag, "_pc"}, wb_pc_o, 0);
    check({tag, "_retire"}, retire_o, 0);
    check({tag, "_instret"}, instret_o, 0);
    check({tag, "_flush"}, flush_o, 0);
    check({tag, "_trap_active"}, trap_active_o, 0);
    check({tag, "_cause"}, trap_cause_o, 0);
    check({tag, "_epc"}, trap_epc_o, 0);
  endtask

  initial begin
    logic [IW-1:0] saved;
    clear_in();
    rst_ni = 1'b1;
    #3 rst_ni = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // ALU writeback
    send(2'd0, 32'h1000, 0, 32'h1234, 5'd5, 1, 0, 0);
    check("alu_we", rf_we_o, 1);
    check("alu_waddr", rf_waddr_o, 5);
    check("alu_data", wb_data_o, 32'h1234);
    check("alu_retire", retire_o, 1);
    check("alu_instret", instret_o, 1);

    // Link values and x0 destination
    send(2'd2, 32'h100, 1, 32'h0, 5'd7, 1, 0, 0);
    check("link_comp", wb_data_o, 32'h102);
    send(2'd2, 32'h100, 0, 32'h0, 5'd7, 1, 0, 0);
    check("link_full", wb_data_o, 32'h104);
    send(2'd2, 32'h100, 0, 32'h0, 5'd0, 1, 0, 0);
    check("x0_we", rf_we_o, 0);
    check("x0_retire", retire_o, 1);
    send(2'd1, 32'h104, 0, 32'h0f0f_0f0f, 5'd9, 1, 0, 0);
    check("load_data", wb_data_o, 32'hf0f0_f0f0);
    send(2'd3, 32'h108, 0, 32'h0000_1111, 5'd9, 1, 0, 0);
    check("csr_data", wb_data_o, 32'h5a5a_1111);

    // Stall for three cycles, then release
    @(negedge clk_i);
    valid_i = 1; stall_i = 1; data_sel_i = 0; alu_result_i = 32'habc; rd_addr_i = 3;
    rf_rw_en_i = 1; pc_i = 32'h10c; exc_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("stall_retire", retire_o, 0);
    end
    stall_i = 0;
    @(negedge clk_i);
    valid_i = 0;
    check("stall_release_retire", retire_o, 1);
    check("stall_release_data", wb_data_o, 32'habc);
    @(negedge clk_i);
    check("single_commit", retire_o, 0);

    // Instret inhibit
    saved = instret_o;
    instret_inhibit_i = 1;
    send(2'd0, 32'h110, 0, 32'h55, 5'd4, 1, 0, 0);
    instret_inhibit_i = 0;
    check("inhibit_retire", retire_o, 1);
    check("inhibit_instret", instret_o, saved);

    // Trap with dropped instruction and early ack during flush
    send(2'd0, 32'h200, 0, 32'h77, 5'd6, 1, 1, 5'd2);
    check("trap_epc", trap_epc_o, 32'h200);
    check("trap_cause", trap_cause_o, 2);
    check("trap_no_retire", retire_o, 0);
    check("trap_flush1", flush_o, 1);
    valid_i = 1; exc_valid_i = 0; trap_ack_i = 1; data_sel_i = 0; rd_addr_i = 8;
    @(negedge clk_i);
    trap_ack_i = 0;
    check("trap_flush2", flush_o, 1);
    @(negedge clk_i);
    check("trap_flush_end", flush_o, 0);
    check("trap_wait_active", trap_active_o, 1);
    repeat (2) @(negedge clk_i);
    check("trap_drop_retire", retire_o, 0);
    valid_i = 0; trap_ack_i = 1;
    @(negedge clk_i);
    trap_ack_i = 0;
    check("trap_ack_clear", trap_active_o, 0);
    // Back-to-back trap in the first idle cycle
    valid_i = 1; exc_valid_i = 1; pc_i = 32'h300; exc_cause_i = 5'd7;
    @(negedge clk_i);
    valid_i = 0; exc_valid_i = 0;
    check("b2b_epc", trap_epc_o, 32'h300);
    check("b2b_active", trap_active_o, 1);
    repeat (3) @(negedge clk_i);
    trap_ack_i = 1;
    @(negedge clk_i);
    trap_ack_i = 0;

    // Counter and link wrap
    saved = instret_o;
    for (int i = 0; i < 16; i++) send(2'd0, 32'h400 + 32'(4 * i), 0, 32'(i), 5'd1, 1, 0, 0);
    check("instret_wrap", instret_o, saved);
    send(2'd2, 32'hffff_fffe, 1, 32'h0, 5'd2, 1, 0, 0);
    check("link_wrap", wb_data_o, 32'h0);

    // Asynchronous reset while waiting for ack
    send(2'd0, 32'h500, 0, 32'h0, 5'd3, 1, 1, 5'd11);
    repeat (2) @(negedge clk_i);
    check("pre_reset_wait", trap_active_o, 1);
    #2 rst_ni = 1'b0;
    #1 check_all_zero("midtrap_reset");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    send(2'd0, 32'h600, 0, 32'h99, 5'd12, 1, 0, 0);
    check("post_reset_data", wb_data_o, 32'h99);
    check("post_reset_instret", instret_o, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      valid_i = ($urandom_range(0, 9) < 7);
      stall_i = ($urandom_range(0, 9) < 2);
      exc_valid_i = ($urandom_range(0, 19) == 0);
      trap_ack_i = ($urandom_range(0, 9) < 3);
      instret_inhibit_i = ($urandom_range(0, 9) == 0);
      data_sel_i = 2'($urandom_range(0, 3));
      pc_i = ($urandom_range(0, 7) == 0) ? (32'hffff_fff8 | 32'($urandom_range(0, 7)))
                                         : $urandom;
      is_comp_i = 1'($urandom_range(0, 1));
      alu_result_i = $urandom; read_data_i = $urandom; csr_rdata_i = $urandom;
      rd_addr_i = 5'($urandom_range(0, 31));
      rf_rw_en_i = 1'($urandom_range(0, 1));
      exc_cause_i = 5'($urandom_range(0, 31));
    end
    @(negedge clk_i);
    clear_in();
    trap_ack_i = 1;
    repeat (6) @(negedge clk_i);
    trap_ack_i = 0;
    repeat (2) @(negedge clk_i);
    check("scoreboard_commits_drained", 64'(exp_q.size()), 0);
    check("scoreboard_traps_drained", 64'(trap_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nerrs);
    $finish;
  end

endmodule
